// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one external 64-bit ALU between two requesters.
// Each operation walks IDLE -> EXEC -> RESP, so a new operation can start every 3 cycles.
module alu_arbiter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  req,
  input  logic [63:0] a0,
  input  logic [63:0] b0,
  input  logic [63:0] a1,
  input  logic [63:0] b1,
  input  logic [2:0]  op0,
  input  logic [2:0]  op1,
  output logic [1:0]  ack,
  output logic [63:0] result,
  output logic [3:0]  flags,
  output logic        done,
  output logic        done_id,
  output logic        busy,
  output logic [63:0] alu_a,
  output logic [63:0] alu_b,
  output logic [2:0]  alu_cntrl,
  input  logic [63:0] alu_result,
  input  logic [3:0]  alu_flags
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state;
  logic             grant;
  logic             ptr;
  logic             win;
  logic [1:0][63:0] a_v;
  logic [1:0][63:0] b_v;
  logic [1:0][2:0]  op_v;

  assign a_v  = {a1, a0};
  assign b_v  = {b1, b0};
  assign op_v = {op1, op0};

  // Pointer only breaks ties; a lone requester always wins.
  assign win = (req == 2'b11) ? ptr : req[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      grant     <= 1'b0;
      ptr       <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_cntrl <= '0;
      result    <= '0;
      flags     <= '0;
      done_id   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|req) begin
          alu_a     <= a_v[win];
          alu_b     <= b_v[win];
          alu_cntrl <= op_v[win];
          grant     <= win;
          state     <= EXEC;
        end
        EXEC: begin
          result  <= alu_result;
          flags   <= alu_flags;
          done_id <= grant;
          state   <= RESP;
        end
        RESP: begin
          ptr   <= ~grant;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes decode from state alone so they last exactly the one RESP cycle.
  assign done = (state == RESP);
  assign busy = (state != IDLE);
  assign ack  = {done & grant, done & ~grant};

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: an abstract requester/arbiter model predicts
// each operation; a separate monitor checks every done strobe against the queue.
module tb_alu_arbiter;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  req = '0;
  logic [63:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [2:0]  op0 = '0, op1 = '0;
  logic [1:0]  ack;
  logic [63:0] result;
  logic [3:0]  flags;
  logic        done, done_id, busy;
  logic [63:0] alu_a, alu_b;
  logic [2:0]  alu_cntrl;
  logic [63:0] alu_result;
  logic [3:0]  alu_flags;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .reset_n(reset_n), .req(req),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .op0(op0), .op1(op1),
    .ack(ack), .result(result), .flags(flags), .done(done), .done_id(done_id),
    .busy(busy), .alu_a(alu_a), .alu_b(alu_b), .alu_cntrl(alu_cntrl),
    .alu_result(alu_result), .alu_flags(alu_flags)
  );

  // External ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 shl, 6 shr, 7 not a.
  // Returns {negative, zero, overflow, carry, result}.
  function automatic logic [67:0] alu_f(input logic [63:0] a, input logic [63:0] b,
                                        input logic [2:0] op);
    logic [64:0] s;
    logic [63:0] r;
    logic        c, v;
    c = 1'b0; v = 1'b0; s = '0;
    case (op)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b}; r = s[63:0]; c = s[64];
        v = (a[63] == b[63]) && (r[63] != a[63]);
      end
      3'd1: begin
        r = a - b; c = (a < b);
        v = (a[63] != b[63]) && (r[63] != a[63]);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = a << b[5:0];
      3'd6: r = a >> b[5:0];
      default: r = ~a;
    endcase
    return {r[63], (r == 64'd0), v, c, r};
  endfunction

  assign {alu_flags, alu_result} = alu_f(alu_a, alu_b, alu_cntrl);

  typedef struct packed {
    logic        id;
    logic [63:0] res;
    logic [3:0]  fl;
  } exp_t;

  exp_t        q[$];
  exp_t        last = '0;
  int          total = 0;
  int          bad = 0;
  int          bcnt = 0;     // model: cycles left in the in-flight operation
  int          cyc = 0;
  logic        ptr_m = 1'b0;
  logic        served = 1'b0;
  logic [1:0]  pend = '0;
  logic [1:0]  auto_rr = '0;
  logic [63:0] ta [2];
  logic [63:0] tb [2];
  logic [2:0]  top [2];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  task automatic new_ops(input int n);
    ta[n]  = {$urandom, $urandom};
    tb[n]  = {$urandom, $urandom};
    top[n] = 3'($urandom_range(7));
  endtask

  task automatic issue(input int n, input logic [63:0] a, input logic [63:0] b,
                       input logic [2:0] op);
    ta[n] = a; tb[n] = b; top[n] = op; pend[n] = 1'b1;
  endtask

  // One clock: requesters act at negedge, the abstract arbiter decides at posedge.
  task automatic drive_cycle(input bit rnd);
    logic w;
    exp_t e;
    @(negedge clk);
    if (bcnt > 0) new_ops(int'(served));
    if (bcnt == 1) pend[served] = 1'b0;
    for (int n = 0; n < 2; n++)
      if (!pend[n] && !(bcnt == 1 && int'(served) == n) &&
          (auto_rr[n] || (rnd && $urandom_range(3) == 0))) begin
        new_ops(n);
        pend[n] = 1'b1;
      end
    req = pend; a0 = ta[0]; b0 = tb[0]; op0 = top[0]; a1 = ta[1]; b1 = tb[1]; op1 = top[1];
    @(posedge clk);
    cyc++;
    if (bcnt > 0) begin
      bcnt--;
      if (bcnt == 0) ptr_m = ~served;
    end else if (pend != 2'b00) begin
      w = (pend == 2'b11) ? ptr_m : pend[1];
      served = w;
      e.id = w;
      {e.fl, e.res} = alu_f(ta[w], tb[w], top[w]);
      q.push_back(e);
      bcnt = 2;
    end
  endtask

  task automatic run_until_done(input bit rnd, output int k);
    k = 0;
    do begin
      drive_cycle(rnd);
      k++;
    end while (bcnt != 1 && k < 20);
    #1;
    if (bcnt != 1) begin
      total++; bad++;
      $display("FAIL done_timeout got=none want=done");
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((pend != 2'b00 || bcnt != 0) && k < 40) begin
      drive_cycle(1'b0);
      k++;
    end
    chk("drain", {62'd0, pend}, 64'd0);
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_ctl"}, {59'd0, ack, done, done_id, busy}, 64'd0);
    chk({nm, "_res"}, result, 64'd0);
    chk({nm, "_flg"}, {60'd0, flags}, 64'd0);
    chk({nm, "_alu"}, alu_a | alu_b | {61'd0, alu_cntrl}, 64'd0);
  endtask

  // Monitor: timing against the model, payload against the scoreboard queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        chk("strobe_timing", {62'd0, done, busy}, {62'd0, bcnt == 1, bcnt != 0});
        if (done) begin
          if (q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_done got=done want=none");
          end else begin
            e = q.pop_front();
            last = e;
            chk("resp_id_ack", {61'd0, done_id, ack}, {61'd0, e.id, e.id, ~e.id});
            chk("resp_result", result, e.res);
            chk("resp_flags", {60'd0, flags}, {60'd0, e.fl});
          end
        end else begin
          chk("ack_idle", {62'd0, ack}, 64'd0);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1);
  end

  initial begin
    int k, c0, c1, c2;
    for (int n = 0; n < 2; n++) begin ta[n] = '0; tb[n] = '0; top[n] = '0; end
    repeat (2) @(posedge clk);
    #3;
    chk_reset_outs("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Single requester, add.
    issue(0, 64'd64357, 64'd26000, 3'd0);
    run_until_done(1'b0, k);
    chk("single_latency", k, 2);
    chk("single_res", result, 64'd90357);
    chk("single_misc", {57'd0, flags, ack, done}, {57'd0, 4'b0000, 2'b01, 1'b1});
    drive_cycle(1'b0);

    // Zero and negative flags.
    issue(0, 64'd5, 64'd5, 3'd1);
    run_until_done(1'b0, k);
    chk("sub_zero_res", result, 64'd0);
    chk("sub_zero_flag", {63'd0, flags[2]}, 64'd1);
    drive_cycle(1'b0);
    issue(0, 64'd3, 64'd5, 3'd1);
    run_until_done(1'b0, k);
    chk("sub_neg_res", result, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("sub_neg_flag", {63'd0, flags[3]}, 64'd1);
    drive_cycle(1'b0);

    // Requester 1 operands scrambled during EXEC/RESP by drive_cycle.
    issue(1, 64'd1000, 64'd234, 3'd0);
    run_until_done(1'b0, k);
    chk("inflight_res", result, 64'd1234);
    chk("inflight_id", {63'd0, done_id}, 64'd1);
    drive_cycle(1'b0);

    // Idle hold.
    drain();
    repeat (10) begin
      drive_cycle(1'b0);
      chk("idle_hold", result ^ last.res, 64'd0);
      chk("idle_hold_ctl", {58'd0, flags, done_id, busy}, {58'd0, last.fl, last.id, 1'b0});
    end

    // Reset in EXEC aborts the operation and clears the pointer.
    issue(1, 64'd7, 64'd8, 3'd0);
    k = 0;
    do begin drive_cycle(1'b0); k++; end while (bcnt != 2 && k < 10);
    #2 reset_n = 1'b0;
    #1 chk_reset_outs("midop_reset");
    q.delete(); bcnt = 0; ptr_m = 1'b0; pend = '0; req = '0;
    #1 reset_n = 1'b1;

    // Contention from a cleared pointer: 0, 1, 0 three cycles apart.
    auto_rr = 2'b11;
    run_until_done(1'b0, k); c0 = cyc; chk("cont_id0", {63'd0, done_id}, 64'd0);
    chk("cont_ack0", {62'd0, ack}, 64'd1);
    run_until_done(1'b0, k); c1 = cyc; chk("cont_id1", {63'd0, done_id}, 64'd1);
    chk("cont_ack1", {62'd0, ack}, 64'd2);
    run_until_done(1'b0, k); c2 = cyc; chk("cont_id2", {63'd0, done_id}, 64'd0);
    chk("cont_gap", {c1 - c0, c2 - c1}, {32'd3, 32'd3});
    auto_rr = 2'b00;
    drain();

    // Randomized traffic.
    repeat (400) drive_cycle(1'b1);
    drain();
    repeat (2) drive_cycle(1'b0);
    chk("queue_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
